// File: rtl/invader_march.sv
// invader_march: alien formation march controller.
// Moves the formation origin one STEP per accepted tick, drops one row and
// reverses at a screen edge, and latches a sticky Landed flag once a drop
// reaches Y_LIMIT.
//
// Handshake: there is no backpressure. A tick is accepted exactly when the
// controller is marching and Tick and Run are both high on the same rising
// edge. Moved is high for the single cycle after that edge, aligned with the
// updated X/Y/Dir/Frame.
module invader_march #(
  parameter int W       = 10,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 400,
  parameter int STEP    = 8,
  parameter int DROP    = 16,
  parameter int Y_START = 32,
  parameter int Y_LIMIT = 416
) (
  input  logic         CLK,
  input  logic         Rst,
  input  logic         Tick,
  input  logic         Run,
  output logic [W-1:0] X,
  output logic [W-1:0] Y,
  output logic         Dir,
  output logic         Frame,
  output logic         Moved,
  output logic         Landed,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MARCH  = 2'd1,
    ST_LANDED = 2'd2
  } state_t;

  // Edge comparisons are done one bit wider than the coordinates so a sum
  // can never wrap around and look in range.
  localparam logic [W:0]   C_STEP     = (W+1)'(STEP);
  localparam logic [W:0]   C_DROP     = (W+1)'(DROP);
  localparam logic [W:0]   C_X_MAX    = (W+1)'(X_MAX);
  localparam logic [W:0]   C_LEFT_LIM = (W+1)'(X_MIN + STEP);
  localparam logic [W:0]   C_Y_LIMIT  = (W+1)'(Y_LIMIT);
  localparam logic [W-1:0] C_X_MIN    = W'(X_MIN);
  localparam logic [W-1:0] C_Y_START  = W'(Y_START);
  localparam logic [W-1:0] C_STEP_W   = W'(STEP);

  state_t         r_state;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_y;
  logic           r_dir;
  logic           r_frame;
  logic           r_moved;
  logic           r_landed;

  state_t         w_next_state;
  logic [W-1:0]   w_x_next;
  logic [W-1:0]   w_y_next;
  logic           w_dir_next;
  logic           w_frame_next;
  logic           w_moved_next;
  logic           w_landed_next;

  logic [W:0]     w_x_plus;
  logic [W:0]     w_y_drop;
  logic           w_right_edge;
  logic           w_left_edge;
  logic           w_at_edge;
  logic           w_accept;

  // Candidate positions and edge detection for the current origin.
  assign w_x_plus     = {1'b0, r_x} + C_STEP;
  assign w_y_drop     = {1'b0, r_y} + C_DROP;
  assign w_right_edge = (w_x_plus > C_X_MAX);
  assign w_left_edge  = ({1'b0, r_x} < C_LEFT_LIM);
  assign w_at_edge    = r_dir ? w_right_edge : w_left_edge;
  assign w_accept     = (r_state == ST_MARCH) && Tick && Run;

  // Next-state and next-position decode; everything holds unless a tick is accepted.
  always_comb begin
    w_next_state  = r_state;
    w_x_next      = r_x;
    w_y_next      = r_y;
    w_dir_next    = r_dir;
    w_frame_next  = r_frame;
    w_moved_next  = 1'b0;
    w_landed_next = r_landed;

    unique case (r_state)
      ST_IDLE: begin
        // Entering MARCH takes one edge; a tick in that cycle is discarded.
        if (Run) begin
          w_next_state = ST_MARCH;
        end
      end

      ST_MARCH: begin
        if (w_accept) begin
          w_moved_next = 1'b1;
          w_frame_next = ~r_frame;
          if (w_at_edge) begin
            // Edge: stay in column, drop a row, turn around.
            w_y_next   = w_y_drop[W-1:0];
            w_dir_next = ~r_dir;
            if (w_y_drop >= C_Y_LIMIT) begin
              w_landed_next = 1'b1;
              w_next_state  = ST_LANDED;
            end
          end else if (r_dir) begin
            w_x_next = w_x_plus[W-1:0];
          end else begin
            // Not at the left edge, so r_x >= X_MIN + STEP and this cannot underflow.
            w_x_next = r_x - C_STEP_W;
          end
        end
      end

      ST_LANDED: begin
        // Frozen until reset.
        w_next_state = ST_LANDED;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (Rst) begin
      r_state  <= ST_IDLE;
      r_x      <= C_X_MIN;
      r_y      <= C_Y_START;
      r_dir    <= 1'b1;
      r_frame  <= 1'b0;
      r_moved  <= 1'b0;
      r_landed <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_x      <= w_x_next;
      r_y      <= w_y_next;
      r_dir    <= w_dir_next;
      r_frame  <= w_frame_next;
      r_moved  <= w_moved_next;
      r_landed <= w_landed_next;
    end
  end

  assign X           = r_x;
  assign Y           = r_y;
  assign Dir         = r_dir;
  assign Frame       = r_frame;
  assign Moved       = r_moved;
  assign Landed      = r_landed;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_invader_march.sv
// tb_invader_march: scoreboard bench for invader_march.
// The driver applies one input vector per cycle at the falling edge, advances
// a plain-integer model of the march rules, and queues the outputs expected
// after the next rising edge. The monitor pops one entry per rising edge and
// compares it against the DUT outputs.
module tb_invader_march;

  localparam int W       = 10;
  localparam int X_MIN   = 0;
  localparam int X_MAX   = 400;
  localparam int STEP    = 8;
  localparam int DROP    = 16;
  localparam int Y_START = 32;
  localparam int Y_LIMIT = 416;
  localparam int OW      = 2*W + 4;

  // ---------------- clock / reset ----------------
  logic         CLK = 1'b0;
  logic         Rst = 1'b1;
  logic         Tick = 1'b0;
  logic         Run = 1'b0;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         Dir;
  logic         Frame;
  logic         Moved;
  logic         Landed;
  logic [1:0]   dbg_state;

  always #5 CLK = ~CLK;

  invader_march #(
    .W(W), .X_MIN(X_MIN), .X_MAX(X_MAX), .STEP(STEP),
    .DROP(DROP), .Y_START(Y_START), .Y_LIMIT(Y_LIMIT)
  ) dut (
    .CLK         (CLK),
    .Rst         (Rst),
    .Tick        (Tick),
    .Run         (Run),
    .X           (X),
    .Y           (Y),
    .Dir         (Dir),
    .Frame       (Frame),
    .Moved       (Moved),
    .Landed      (Landed),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // mode: 0 waiting for Run, 1 marching, 2 landed
  int m_mode   = 0;
  int m_x      = X_MIN;
  int m_y      = Y_START;
  bit m_dir    = 1'b1;
  bit m_frame  = 1'b0;
  bit m_moved  = 1'b0;
  bit m_landed = 1'b0;

  function automatic logic [OW-1:0] pack_out(input int x, input int y, input bit d,
                                             input bit f, input bit mv, input bit ld);
    return {W'(x), W'(y), d, f, mv, ld};
  endfunction

  task automatic model_step(input bit rst, input bit tick, input bit run);
    bool_edge: begin
      bit edge_hit;
      if (rst) begin
        m_mode = 0; m_x = X_MIN; m_y = Y_START;
        m_dir = 1'b1; m_frame = 1'b0; m_moved = 1'b0; m_landed = 1'b0;
      end else begin
        m_moved = 1'b0;
        if (m_mode == 0) begin
          if (run) m_mode = 1;
        end else if (m_mode == 1 && tick && run) begin
          m_moved  = 1'b1;
          m_frame  = ~m_frame;
          edge_hit = m_dir ? (m_x + STEP > X_MAX) : (m_x - STEP < X_MIN);
          if (edge_hit) begin
            m_y   = m_y + DROP;
            m_dir = ~m_dir;
            if (m_y >= Y_LIMIT) begin
              m_landed = 1'b1;
              m_mode   = 2;
            end
          end else begin
            m_x = m_dir ? m_x + STEP : m_x - STEP;
          end
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit tick, input bit run);
    @(negedge CLK);
    Rst  = rst;
    Tick = tick;
    Run  = run;
    model_step(rst, tick, run);
    exp_q.push_back(pack_out(m_x, m_y, m_dir, m_frame, m_moved, m_landed));
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [OW-1:0] exp_v;
    logic [OW-1:0] act_v;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {X, Y, Dir, Frame, Moved, Landed};
        n_checks++;
        if (act_v === exp_v) begin
          n_pass++;
        end else begin
          $display("FAIL outputs t=%0t actual X=%0d Y=%0d Dir=%0b Frame=%0b Moved=%0b Landed=%0b required X=%0d Y=%0d Dir=%0b Frame=%0b Moved=%0b Landed=%0b",
                   $time, X, Y, Dir, Frame, Moved, Landed,
                   exp_v[OW-1 -: W], exp_v[OW-W-1 -: W], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;

    // Reset for two cycles, then ticks with Run low change nothing.
    repeat (2) drive(1'b1, 1'b0, 1'b0);
    repeat (6) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // Run rises together with a tick: the tick is not taken.
    drive(1'b0, 1'b1, 1'b1);

    // Three spaced ticks: X 8, 16, 24 and Frame 1, 0, 1.
    repeat (3) begin
      repeat (16) drive(1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 1'b1);
    end

    // Random march with back-to-back ticks and pauses until the formation lands,
    // crossing both edges many times on the way down.
    budget = 0;
    while (m_mode != 2 && budget < 20000) begin
      drive(1'b0, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) != 0));
      budget++;
    end
    if (m_mode != 2) begin
      n_checks++;
      $display("FAIL landing_budget actual cycles=%0d required landing before 20000", budget);
    end

    // Landed: further ticks freeze everything.
    repeat (5) begin
      drive(1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1);
    end

    // Reset out of LANDED, restart and march to X=192.
    repeat (2) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    budget = 0;
    while (m_x < 192 && budget < 200) begin
      drive(1'b0, 1'b1, 1'b1);
      budget++;
    end

    // Pause for 40 cycles containing 2 ticks; X must hold.
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, (i == 10 || i == 30), 1'b0);
    end

    // Run falling in the same cycle as a tick rejects it.
    drive(1'b0, 1'b1, 1'b0);

    // Run back: next tick moves to 200, then reset with a tick returns to X=0.
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    repeat (3) drive(1'b0, 1'b0, 1'b0);

    // Fully random traffic including occasional resets.
    repeat (3000) begin
      drive(1'($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) != 0));
    end
    drive(1'b0, 1'b0, 1'b0);

    // Every queued expectation must have been consumed by the monitor.
    @(posedge CLK);
    #2;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL queue_drain actual pending=%0d required pending=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
